// File: rtl/vroom_rom_arbiter.sv
// vroom_rom_arbiter
// -----------------
// Shares the single-port on-chip ROM (word addressed, one-cycle read latency)
// between the CPU instruction-fetch master (i_*) and the CPU data/debug master
// (d_*). Both masters are Avalon-MM pipelined; the ROM is an Avalon-MM slave.
//
// At most one access is granted per cycle. The grant is combinational in the
// request cycle, so a lone requester never waits. Under contention the data
// port wins until it has taken MAX_CONSEC grants in a row while the
// instruction port was waiting; the instruction port then gets the next slot.
// Read data returns one cycle after acceptance, tagged to the owning port.
//
// Ports
//   clk, reset         : system clock, synchronous active-high reset
//   i_address/i_read   : instruction fetch request
//   i_waitrequest      : instruction request not accepted this cycle
//   i_readdata/valid   : instruction read response
//   d_address          : data/debug word address
//   d_read/d_write     : data read/write requests (both high means write)
//   d_byteenable       : write byte lanes
//   d_writedata        : write data
//   d_debugaccess      : debug qualifier, ROM commits writes only when set
//   d_waitrequest      : data request not accepted this cycle
//   d_readdata/valid   : data read response
//   rom_*              : ROM slave command (address, chipselect, write,
//                        byteenable, writedata, debugaccess, clken)
//   rom_readdata       : ROM output, valid the cycle after the address edge

module vroom_rom_arbiter #(
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MAX_CONSEC = 4
) (
   input  logic                clk,
   input  logic                reset,

   // Instruction-fetch master
   input  logic [ADDR_W-1:0]   i_address,
   input  logic                i_read,
   output logic                i_waitrequest,
   output logic [DATA_W-1:0]   i_readdata,
   output logic                i_readdatavalid,

   // Data/debug master
   input  logic [ADDR_W-1:0]   d_address,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [DATA_W/8-1:0] d_byteenable,
   input  logic [DATA_W-1:0]   d_writedata,
   input  logic                d_debugaccess,
   output logic                d_waitrequest,
   output logic [DATA_W-1:0]   d_readdata,
   output logic                d_readdatavalid,

   // ROM slave
   output logic [ADDR_W-1:0]   rom_address,
   output logic                rom_chipselect,
   output logic                rom_write,
   output logic [DATA_W/8-1:0] rom_byteenable,
   output logic [DATA_W-1:0]   rom_writedata,
   output logic                rom_debugaccess,
   output logic                rom_clken,
   input  logic [DATA_W-1:0]   rom_readdata
);

   localparam int unsigned BE_W      = DATA_W / 8;
   localparam logic [3:0]  MaxConsec = 4'(MAX_CONSEC);

   // ------------------------------------------------------------------------
   // Request decode and grant
   // ------------------------------------------------------------------------
   logic i_req;
   logic d_req;
   logic starve_hit;
   logic grant_i;
   logic grant_d;
   logic grant_any;
   logic d_wr_grant;

   logic [3:0] starve_q, starve_d;
   logic       rsp_vld_q, rsp_vld_d;
   logic       rsp_own_q, rsp_own_d;   // 0 = instruction, 1 = data

   always_comb begin
      i_req      = i_read;
      // A simultaneous read and write is treated as a write.
      d_req      = d_read | d_write;
      starve_hit = (starve_q == MaxConsec);

      // Data has priority unless the fetch port has waited MAX_CONSEC slots.
      grant_d    = ~reset & d_req & (~i_req | ~starve_hit);
      grant_i    = ~reset & i_req & ~grant_d;
      grant_any  = grant_i | grant_d;
      d_wr_grant = grant_d & d_write;
   end

   // ------------------------------------------------------------------------
   // Master handshakes
   // ------------------------------------------------------------------------
   always_comb begin
      // An idle port sees waitrequest low; during reset nothing is accepted.
      i_waitrequest = reset | (i_req & ~grant_i);
      d_waitrequest = reset | (d_req & ~grant_d);
   end

   // ------------------------------------------------------------------------
   // ROM command
   // ------------------------------------------------------------------------
   always_comb begin
      rom_chipselect  = grant_any;
      rom_address     = grant_d ? d_address : i_address;
      rom_write       = d_wr_grant;
      rom_byteenable  = d_wr_grant ? d_byteenable : {BE_W{1'b1}};
      rom_writedata   = d_writedata;
      rom_debugaccess = grant_d & d_debugaccess;
      rom_clken       = 1'b1;
   end

   // ------------------------------------------------------------------------
   // Starvation counter: consecutive data grants while the fetch port waits
   // ------------------------------------------------------------------------
   always_comb begin
      starve_d = starve_q;
      if (!i_req || grant_i) begin
         starve_d = 4'd0;
      end else if (grant_d && !starve_hit) begin
         starve_d = starve_q + 4'd1;
      end
   end

   // ------------------------------------------------------------------------
   // Response pipeline: one entry is enough since read latency is one cycle
   // ------------------------------------------------------------------------
   always_comb begin
      rsp_vld_d = grant_i | (grant_d & ~d_write);
      rsp_own_d = grant_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q  <= 4'd0;
         rsp_vld_q <= 1'b0;
         rsp_own_q <= 1'b0;
      end else begin
         starve_q  <= starve_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_own_q <= rsp_own_d;
      end
   end

   // ------------------------------------------------------------------------
   // Read responses
   // ------------------------------------------------------------------------
   always_comb begin
      // Reset arriving in the response cycle drops the pending response.
      i_readdatavalid = ~reset & rsp_vld_q & ~rsp_own_q;
      d_readdatavalid = ~reset & rsp_vld_q &  rsp_own_q;
      i_readdata      = rom_readdata;
      d_readdata      = rom_readdata;
   end

   // ------------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------------
   grant_onehot_a : assert property (@(posedge clk) !(grant_i && grant_d));
   starve_range_a : assert property (@(posedge clk) disable iff (reset)
                                     starve_q <= MaxConsec);
   rsp_onehot_a   : assert property (@(posedge clk)
                                     !(i_readdatavalid && d_readdatavalid));

endmodule
